// File: rtl/swap_regfile_p.sv
// Parametrised register file: two registered read ports, one write port and an
// atomic three-cycle two-entry swap engine.
module swap_regfile_p #(
    parameter int unsigned       DATA_W  = 8,
    parameter int unsigned       ADDR_W  = 5,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] r_addr0,
    input  logic [ADDR_W-1:0] r_addr1,
    output logic [DATA_W-1:0] dout0,
    output logic [DATA_W-1:0] dout1,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] din,
    input  logic              wr_en,
    output logic              wr_drop,
    input  logic              swap_req,
    input  logic [ADDR_W-1:0] swap_a,
    input  logic [ADDR_W-1:0] swap_b,
    output logic              busy,
    output logic              swap_done
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SWAP_RD = 2'd1,
        SWAP_WR = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] a_q;
    logic [ADDR_W-1:0] b_q;
    logic [DATA_W-1:0] tmp_a;
    logic [DATA_W-1:0] tmp_b;
    logic              wr_fire_c;
    logic              latch_c;
    logic [ADDR_W-1:0] ra_c [2];
    logic [DATA_W-1:0] rd_c [2];

    assign ra_c[0] = r_addr0;
    assign ra_c[1] = r_addr1;

    // Swap FSM next-state; writes are only accepted while idle.
    always_comb begin
        state_next = state;
        wr_fire_c  = 1'b0;
        latch_c    = 1'b0;
        case (state)
            IDLE: begin
                wr_fire_c = wr_en;
                if (swap_req) begin
                    latch_c    = 1'b1;
                    state_next = SWAP_RD;
                end
            end
            SWAP_RD: state_next = SWAP_WR;
            SWAP_WR: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Write-first read bypass; the swap commit wins over plain storage.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_c[p] = mem[ra_c[p]];
            if (wr_fire_c && (ra_c[p] == w_addr)) rd_c[p] = din;
            if ((state == SWAP_WR) && (ra_c[p] == a_q)) rd_c[p] = tmp_b;
            if ((state == SWAP_WR) && (ra_c[p] == b_q)) rd_c[p] = tmp_a;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= RST_VAL;
            end
            dout0     <= RST_VAL;
            dout1     <= RST_VAL;
            a_q       <= '0;
            b_q       <= '0;
            tmp_a     <= '0;
            tmp_b     <= '0;
            busy      <= 1'b0;
            wr_drop   <= 1'b0;
            swap_done <= 1'b0;
        end else begin
            if (wr_fire_c) mem[w_addr] <= din;
            if (state == SWAP_WR) begin
                mem[a_q] <= tmp_b;
                mem[b_q] <= tmp_a;
            end
            if (latch_c) begin
                a_q <= swap_a;
                b_q <= swap_b;
            end
            if (state == SWAP_RD) begin
                tmp_a <= mem[a_q];
                tmp_b <= mem[b_q];
            end
            dout0     <= rd_c[0];
            dout1     <= rd_c[1];
            busy      <= (state_next != IDLE);
            wr_drop   <= wr_en && (state != IDLE);
            swap_done <= (state == SWAP_WR);
        end
    end

endmodule
